mod_add_serial: RTL and testbench



---
 rtl/secp256k1_pkg.sv | 16 +
 rtl/mod_add_serial_if.sv | 22 ++
 rtl/limb_addsub.sv | 20 ++
 rtl/mod_add_serial.sv | 97 +++++++++
 tb/tb_mod_add_serial.sv | 144 ++++++++++++++
 5 files changed

// File: rtl/secp256k1_pkg.sv
// secp256k1_pkg: shared field constants and FSM state encoding for the serial field adder.
package secp256k1_pkg;
  localparam int FIELD_W = 256;
  localparam logic [FIELD_W-1:0] SECP_P =
    256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADD  = 2'd1;
  localparam logic [1:0] ST_RED  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;
  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    ADD  = ST_ADD,
    RED  = ST_RED,
    DONE = ST_DONE
  } state_t;
endpackage

// File: rtl/mod_add_serial_if.sv
// mod_add_serial_if: operand/result handshake bundle for mod_add_serial.
//   in_valid/in_ready + x, y (+ op when MOD_ADD_SERIAL_SUB_EN) : operand side
//   out_valid/out_ready + sum                                  : result side
//   master = producer/consumer side, slave = the adder.
interface mod_add_serial_if;
  import secp256k1_pkg::*;
  logic               in_valid;
  logic               in_ready;
  logic [FIELD_W-1:0] x;
  logic [FIELD_W-1:0] y;
  logic               out_valid;
  logic               out_ready;
  logic [FIELD_W-1:0] sum;
`ifdef MOD_ADD_SERIAL_SUB_EN
  logic               op;
  modport master (output in_valid, x, y, op, out_ready, input in_ready, out_valid, sum);
  modport slave  (input in_valid, x, y, op, out_ready, output in_ready, out_valid, sum);
`else
  modport master (output in_valid, x, y, out_ready, input in_ready, out_valid, sum);
  modport slave  (input in_valid, x, y, out_ready, output in_ready, out_valid, sum);
`endif
endinterface

// File: rtl/limb_addsub.sv
// limb_addsub: combinational LIMB_W-bit add/subtract on a LIMB_W+1-bit adder.
//   a, b : limb operands     ci  : carry-in (add) or borrow-in (sub)
//   sub  : 1 = a - b - ci    r   : limb result
//   co   : carry-out (add) or borrow-out (sub)
module limb_addsub #(
  parameter int LIMB_W = 64
) (
  input  logic [LIMB_W-1:0] a,
  input  logic [LIMB_W-1:0] b,
  input  logic              ci,
  input  logic              sub,
  output logic [LIMB_W-1:0] r,
  output logic              co
);
  logic [LIMB_W:0] t;
  // a negative difference wraps, leaving the borrow in the extra top bit
  assign t = sub ? {1'b0, a} - {1'b0, b} - (LIMB_W+1)'(ci)
                 : {1'b0, a} + {1'b0, b} + (LIMB_W+1)'(ci);
  assign {co, r} = t;
endmodule

// File: rtl/mod_add_serial.sv
// mod_add_serial: limb-serial (x + y) mod p over the secp256k1 prime, one LIMB_W slice per clock.
//   clk   : rising-edge clock
//   reset : asynchronous, active-low
//   bus   : mod_add_serial_if.slave (in_valid/in_ready/x/y, out_valid/out_ready/sum)
//   MOD_ADD_SERIAL_SUB_EN adds bus.op (1 = (x - y) mod p), sampled at accept.
//   out_valid is first seen after the 2*N_LIMBS+1-th edge, counting the accept edge as the first.
module mod_add_serial
  import secp256k1_pkg::*;
#(
  parameter int LIMB_W = 64
) (
  input logic clk,
  input logic reset,
  mod_add_serial_if.slave bus
);
  localparam int N_LIMBS = FIELD_W / LIMB_W;
  localparam int CW = N_LIMBS > 1 ? $clog2(N_LIMBS) : 1;
  state_t state, state_nx;
  logic [FIELD_W-1:0] x_r, y_r, s_r, d_r, sum_r, d_nx;
  logic [CW-1:0] cnt;
  logic [LIMB_W-1:0] a, b, r;
  logic cy, c_add, sub, co, last, sel;
`ifdef MOD_ADD_SERIAL_SUB_EN
  logic op_r;
`else
  localparam logic op_r = 1'b0;
`endif
  assign last = cnt == CW'(N_LIMBS - 1);
  // ADD works on x/y; RED folds p into the stored first-pass value (subtract for add, add for sub)
  always_comb begin
    a = state == RED ? s_r[cnt*LIMB_W +: LIMB_W] : x_r[cnt*LIMB_W +: LIMB_W];
    b = state == RED ? SECP_P[cnt*LIMB_W +: LIMB_W] : y_r[cnt*LIMB_W +: LIMB_W];
    sub = state == RED ? ~op_r : op_r;
  end
  limb_addsub #(.LIMB_W(LIMB_W)) u_limb (
    .a  (a),
    .b  (b),
    .ci (cy),
    .sub(sub),
    .r  (r),
    .co (co)
  );
  always_comb begin
    d_nx = d_r;
    d_nx[cnt*LIMB_W +: LIMB_W] = r;
  end
  // add: take s - p on overflow or when s >= p; sub: take (x - y) + p when x - y borrowed
  assign sel = op_r ? c_add : (c_add | ~co);
  always_comb begin
    state_nx = state == IDLE ? (bus.in_valid ? ADD : IDLE)
             : state == ADD  ? (last ? RED : ADD)
             : state == RED  ? (last ? DONE : RED)
             : (bus.out_ready ? IDLE : DONE);
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      x_r   <= '0;
      y_r   <= '0;
      s_r   <= '0;
      d_r   <= '0;
      sum_r <= '0;
      cnt   <= '0;
      cy    <= 1'b0;
      c_add <= 1'b0;
`ifdef MOD_ADD_SERIAL_SUB_EN
      op_r  <= 1'b0;
`endif
    end else begin
      if (state == IDLE && bus.in_valid) begin
        x_r <= bus.x;
        y_r <= bus.y;
        cnt <= '0;
        cy  <= 1'b0;
`ifdef MOD_ADD_SERIAL_SUB_EN
        op_r <= bus.op;
`endif
      end
      if (state == ADD || state == RED) begin
        cnt <= last ? '0 : cnt + 1'b1;
        cy  <= last ? 1'b0 : co;
      end
      if (state == ADD) begin
        s_r[cnt*LIMB_W +: LIMB_W] <= r;
        if (last) c_add <= co;
      end
      if (state == RED) begin
        d_r <= d_nx;
        if (last) sum_r <= sel ? d_nx : s_r;
      end
    end
  assign bus.in_ready  = state == IDLE;
  assign bus.out_valid = state == DONE;
  assign bus.sum       = sum_r;
endmodule

// File: tb/tb_mod_add_serial.sv
// tb_mod_add_serial: directed and random checks of mod_add_serial against an arithmetic reference.
module tb_mod_add_serial;
  localparam logic [255:0] P_REF = ~256'd0 - 256'h1_0000_0000 - 256'd977 + 256'd1;
  localparam int LAT = 2 * (256 / 64) + 1;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic cur_op = 1'b0;
  int nchk = 0;
  int nerr = 0;
  mod_add_serial_if bus ();
  mod_add_serial dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );
  always #5 clk = ~clk;
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  function automatic logic [255:0] model(input logic [255:0] a, input logic [255:0] b, input logic o);
    logic [256:0] t;
    if (o) t = (a >= b) ? {1'b0, a} - {1'b0, b} : {1'b0, a} + {1'b0, P_REF} - {1'b0, b};
    else begin
      t = {1'b0, a} + {1'b0, b};
      if (t >= {1'b0, P_REF}) t = t - {1'b0, P_REF};
    end
    return t[255:0];
  endfunction
  function automatic logic [255:0] rnd();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v >= P_REF ? v - P_REF : v;
  endfunction
  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    nchk++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic launch(input logic [255:0] a, input logic [255:0] b);
    @(negedge clk);
    chk("in_ready_idle", 256'(bus.in_ready), 256'd1);
    bus.x = a;
    bus.y = b;
    bus.in_valid = 1'b1;
`ifdef MOD_ADD_SERIAL_SUB_EN
    bus.op = cur_op;
`endif
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask
  task automatic wait_valid();
    int n = 1;
    while (bus.out_valid !== 1'b1 && n < 4 * LAT) begin
      @(negedge clk);
      n++;
    end
    chk("latency", 256'(n), 256'(LAT));
  endtask
  task automatic ack(input logic [255:0] e);
    chk("sum", bus.sum, e);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("out_valid_drop", 256'(bus.out_valid), 256'd0);
    chk("in_ready_back", 256'(bus.in_ready), 256'd1);
    chk("sum_kept", bus.sum, e);
  endtask
  task automatic xact(input logic [255:0] a, input logic [255:0] b, input logic [255:0] e);
    launch(a, b);
    wait_valid();
    ack(e);
  endtask
  initial begin
    logic [255:0] xa, ya, two255;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.x = '0;
    bus.y = '0;
`ifdef MOD_ADD_SERIAL_SUB_EN
    bus.op = 1'b0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 256'(bus.in_ready), 256'd1);
    chk("rst_out_valid", 256'(bus.out_valid), 256'd0);
    chk("rst_sum", bus.sum, 256'd0);
    reset = 1'b1;
    xact(256'd0, 256'd0, 256'd0);
    xact(P_REF - 256'd1, 256'd1, 256'd0);
    xact(P_REF - 256'd1, P_REF - 256'd1,
         256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2D);
    two255 = 256'd1 << 255;
    launch(two255, two255);
    wait_valid();
    for (int i = 0; i < 20; i++) begin
      bus.in_valid = 1'b1;
      bus.x = 256'd123;
      bus.y = 256'd456;
      @(negedge clk);
      chk("bp_valid", 256'(bus.out_valid), 256'd1);
      chk("bp_sum", bus.sum, 256'h1_000003D1);
      chk("bp_in_ready", 256'(bus.in_ready), 256'd0);
    end
    bus.in_valid = 1'b0;
    ack(256'h1_000003D1);
    @(negedge clk);
    chk("idle_stays", 256'(bus.in_ready), 256'd1);
    launch(P_REF - 256'd1, P_REF - 256'd1);
    repeat (5) @(negedge clk);
    chk("busy_red", 256'(bus.in_ready), 256'd0);
    reset = 1'b0;
    #1;
    chk("abort_out_valid", 256'(bus.out_valid), 256'd0);
    chk("abort_in_ready", 256'(bus.in_ready), 256'd1);
    chk("abort_sum", bus.sum, 256'd0);
    @(negedge clk);
    reset = 1'b1;
    xact(256'd5, 256'd7, 256'd12);
`ifdef MOD_ADD_SERIAL_SUB_EN
    cur_op = 1'b1;
    xact(256'd3, 256'd5, P_REF - 256'd2);
    xact(256'd5, 256'd3, 256'd2);
    cur_op = 1'b0;
`endif
    for (int i = 0; i < 24; i++) begin
      xa = rnd();
      ya = (i % 4 == 0) ? P_REF - 256'd1 - xa
         : (i % 4 == 1 && xa != 256'd0) ? P_REF - xa
         : (i % 4 == 2) ? 256'($urandom_range(0, 1000))
         : rnd();
`ifdef MOD_ADD_SERIAL_SUB_EN
      cur_op = 1'($urandom_range(0, 1));
`endif
      xact(xa, ya, model(xa, ya, cur_op));
    end
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
